// File: rtl/imap_biu_pkg.sv
// Shared constants and FSM encoding for the input feature map buffer and its write front end.
package imap_biu_pkg;

  localparam int unsigned NUM_BANKS  = 7;
  localparam int unsigned BANK_DEPTH = 4096;
  localparam int unsigned IMAP_DEPTH = NUM_BANKS * BANK_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } imap_state_e;

endpackage

// File: rtl/imap_biu.sv
// Write-side bus interface of the input feature map buffer: turns a (base, len) burst command plus a
// valid/ready data stream into one registered buffer write per accepted beat.
module imap_biu
  import imap_biu_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BUF_DEPTH = IMAP_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] imap_waddr,
  output logic [DATA_W-1:0] imap_wdata,
  output logic              imap_wen,
  output logic              done,
  output logic              err,
  output logic              busy
);

  imap_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wen_d, done_d, err_d;
  logic              cmd_fire, beat;
  logic [ADDR_W:0]   end_addr;
  logic              in_range;

  // Handshakes are decoded combinationally so rd_req and soft_clr stall the stream in the same cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !soft_clr;
  assign s_ready   = (state_q == ST_XFER) && !rd_req && !soft_clr;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat      = s_valid && s_ready;

  // One extra bit so base+len can never wrap into a legal range.
  assign end_addr = {1'b0, cmd_base} + (ADDR_W+1)'(cmd_len);
  assign in_range = end_addr <= (ADDR_W+1)'(BUF_DEPTH);

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    waddr_d    = imap_waddr;
    wdata_d    = imap_wdata;
    wen_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (!in_range) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_XFER;
            cur_addr_d = cmd_base;
            remain_d   = cmd_len;
          end
        end
      end
      ST_XFER: begin
        if (beat) begin
          wen_d      = 1'b1;
          waddr_d    = cur_addr_q;
          wdata_d    = s_data;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d   = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort drops the rest of the burst; handshakes are already gated above.
    if (soft_clr) begin
      state_d    = ST_IDLE;
      cur_addr_d = '0;
      remain_d   = '0;
      wen_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      imap_waddr <= '0;
      imap_wdata <= '0;
      imap_wen   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      imap_waddr <= waddr_d;
      imap_wdata <= wdata_d;
      imap_wen   <= wen_d;
      done       <= done_d;
      err        <= err_d;
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule
